lut_cell_mux_tree: RTL and testbench

//  Programmable logic cell: each lane evaluates an N_IN-input Boolean function through a 2:1 mux tree

---
 rtl/lut_cell_mux_tree_if.sv | 28 ++
 rtl/lut_cell_mux_tree.sv | 138 +++++++++++++
 tb/tb_lut_cell_mux_tree.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_cell_mux_tree_if.sv
// Bundle of configuration, input-stream and output-stream signals for lut_cell_mux_tree.
// The master drives the table load and the input beats; the slave is the LUT cell.
interface lut_cell_mux_tree_if #(
    parameter int N_IN  = 2,
    parameter int LANES = 4
);
    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_bit;
    logic                  cfg_busy;
    logic                  cfg_done;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*N_IN-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
        input  cfg_busy, cfg_done, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
        output cfg_busy, cfg_done, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_cell_mux_tree.sv
// Multi-lane LUT cell: per-lane 2:1 mux tree over a shared, serially loaded truth table.
// Define LUT_SHADOW_RUN_EN to keep the datapath accepting beats while a new table loads.
module lut_cell_mux_tree #(
    parameter int                    N_IN     = 2,
    parameter int                    LANES    = 4,
    parameter logic [(1<<N_IN)-1:0]  INIT_TBL = 4'b0101
) (
    input  logic                clk,
    input  logic                rst_n,
    lut_cell_mux_tree_if.slave  bus
);
    localparam int T  = 1 << N_IN;
    localparam int CW = N_IN + 1;
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [T-1:0]     tbl;
    logic [T-1:0]     shadow;
    logic             commit;
    logic             commit_nxt;
    logic             shadow_we;
    logic             dp_en;
    logic             in_ready;
    logic             accept;
    logic             out_valid;
    logic [LANES-1:0] out_data;
    logic [LANES-1:0] eval;

`ifdef LUT_SHADOW_RUN_EN
    assign dp_en = 1'b1;
`else
    assign dp_en = (state == RUN);
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        commit_nxt = 1'b0;
        shadow_we  = 1'b0;
        case (state)
            RUN: begin
                if (bus.cfg_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                // A restart wins over a simultaneous bit; that bit is dropped.
                if (bus.cfg_start) begin
                    cnt_nxt = '0;
                end else if (bus.cfg_valid) begin
                    shadow_we = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_nxt  = RUN;
                        commit_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            cnt    <= '0;
            commit <= 1'b0;
            shadow <= INIT_TBL;
            tbl    <= INIT_TBL;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            commit <= commit_nxt;
            if (shadow_we) begin
                shadow[cnt[N_IN-1:0]] <= bus.cfg_bit;
            end
            // Swap happens at the end of the cfg_done cycle so beats accepted in it see the old table.
            if (commit) begin
                tbl <= shadow;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [N_IN-1:0] sel;
        logic [2*T-1:1]  node;

        assign sel = bus.in_data[k*N_IN +: N_IN];

        // Heap-ordered tree: leaves at T..2T-1, root at 1; lowest select bit at the leaf level.
        always_comb begin
            node = '0;
            for (int unsigned m = 0; m < T; m++) begin
                node[T + m] = tbl[m];
            end
            for (int unsigned l = 0; l < N_IN; l++) begin
                for (int unsigned i = (1 << (N_IN - 1 - l)); i < (1 << (N_IN - l)); i++) begin
                    node[i] = sel[l] ? node[2*i + 1] : node[2*i];
                end
            end
        end

        assign eval[k] = node[1];
    end

    assign in_ready = (!out_valid || bus.out_ready) && dp_en;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= eval;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.cfg_busy  = (state == LOAD);
    assign bus.cfg_done  = commit;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(T));
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) !(commit && state == LOAD));
endmodule

// File: tb/tb_lut_cell_mux_tree.sv
// Directed bench for lut_cell_mux_tree (N_IN=2, LANES=4): vector table plus load/stall/reset sequences.
// Expectations follow LUT_SHADOW_RUN_EN when it is defined for the build.
module tb_lut_cell_mux_tree;
    localparam int N_IN  = 2;
    localparam int LANES = 4;
`ifdef LUT_SHADOW_RUN_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lut_cell_mux_tree_if #(.N_IN(N_IN), .LANES(LANES)) bus ();

    lut_cell_mux_tree #(
        .N_IN     (N_IN),
        .LANES    (LANES),
        .INIT_TBL (4'b0101)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] phase;
        logic [7:0] din;
        logic [3:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    logic       m_valid;
    logic [3:0] m_data;
    logic [3:0] m_tbl;
    logic       m_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [3:0] model_eval(input logic [3:0] t, input logic [7:0] d);
        logic [3:0] r;
        logic [1:0] idx;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            idx  = d[2*k +: 2];
            r[k] = t[idx];
        end
        return r;
    endfunction

    // One clock of stimulus, checked against the output-register model.
    task automatic drive_cycle(input logic iv, input logic [7:0] din, input logic ordy,
                               input logic cs, input logic cv, input logic cb, output logic acc);
        logic m_ready;
        bus.in_valid  = iv;
        bus.in_data   = din;
        bus.out_ready = ordy;
        bus.cfg_start = cs;
        bus.cfg_valid = cv;
        bus.cfg_bit   = cb;
        #1;
        m_ready = (!m_valid || ordy) && m_en;
        check("in_ready", bus.in_ready, m_ready);
        acc = iv && m_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            m_data  = model_eval(m_tbl, din);
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) check("out_data", bus.out_data, m_data);
    endtask

    task automatic run_phase(input logic [1:0] p);
        logic acc;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == p) begin
                drive_cycle(1'b1, vecs[i].din, 1'b1, 1'b0, 1'b0, 1'b0, acc);
                check("vec_out", bus.out_data, vecs[i].exp);
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic load_seq(input logic [3:0] bits, input logic stream);
        logic acc;
        drive_cycle(stream, 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, acc);
        check("busy_after_start", bus.cfg_busy, 1);
        check("done_after_start", bus.cfg_done, 0);
        m_en = SHADOW;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(stream, 8'($urandom), 1'(i != 1), 1'b0, 1'b1, bits[i], acc);
            check("busy_load", bus.cfg_busy, (i != 3));
            check("done_load", bus.cfg_done, (i == 3));
        end
        m_en = 1'b1;
        drive_cycle(stream, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("done_after_commit", bus.cfg_done, 0);
        m_tbl = bits;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic       acc;
        int         acc_cnt;
        logic [3:0] xb;

        vecs[0]  = '{2'd0, 8'hE4, 4'b0101};
        vecs[1]  = '{2'd0, 8'h00, 4'b1111};
        vecs[2]  = '{2'd0, 8'hFF, 4'b0000};
        vecs[3]  = '{2'd0, 8'hAA, 4'b1111};
        vecs[4]  = '{2'd0, 8'h1B, 4'b1010};
        vecs[5]  = '{2'd1, 8'hFF, 4'b1111};
        vecs[6]  = '{2'd1, 8'hAA, 4'b0000};
        vecs[7]  = '{2'd1, 8'hE4, 4'b1000};
        vecs[8]  = '{2'd1, 8'h1B, 4'b0001};
        vecs[9]  = '{2'd2, 8'hE4, 4'b0110};
        vecs[10] = '{2'd2, 8'h00, 4'b0000};
        vecs[11] = '{2'd2, 8'h55, 4'b1111};
        vecs[12] = '{2'd2, 8'h1B, 4'b0110};
        vecs[13] = '{2'd2, 8'hAA, 4'b1111};

        rst_n = 1'b0;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_tbl   = 4'b0101;
        m_en    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.cfg_busy, 0);
        check("rst_done", bus.cfg_done, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset table is NOT of lane bit 0
        run_phase(2'd0);

        // AND table, idle datapath
        load_seq(4'b1000, 1'b0);
        run_phase(2'd1);

        // Output stall then random flow control
        drive_cycle(1'b1, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("stall_first", bus.out_data, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, acc);
            check("stall_hold", bus.out_data, 4'b1000);
            check("stall_in_ready", bus.in_ready, 0);
        end
        drive_cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("stall_release", bus.out_data, 4'b1111);
        acc_cnt = 0;
        for (int c = 0; c < 200 && acc_cnt < 32; c++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                        1'b0, 1'b0, 1'b0, acc);
            if (acc) acc_cnt++;
        end
        check("beats_accepted", acc_cnt, 32);

        // OR table loaded while streaming
        load_seq(4'b1110, 1'b1);
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, acc);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, acc);

        // Restarted load: bit in RUN ignored, bit alongside restart dropped, single cfg_done
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        check("run_bit_busy", bus.cfg_busy, 0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        m_en = SHADOW;
        check("t5_busy_start", bus.cfg_busy, 1);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, acc);
            check("t5_partial_done", bus.cfg_done, 0);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        check("t5_restart_busy", bus.cfg_busy, 1);
        check("t5_restart_done", bus.cfg_done, 0);
        xb = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, xb[i], acc);
            check("t5_busy", bus.cfg_busy, (i != 3));
            check("t5_done", bus.cfg_done, (i == 3));
        end
        m_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, acc);
            check("t5_single_done", bus.cfg_done, 0);
        end
        m_tbl = 4'b0110;
        run_phase(2'd2);

        // Reset in the middle of a load
        drive_cycle(1'b1, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("t6_pre_data", bus.out_data, 4'b0110);
        drive_cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        m_en = SHADOW;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        end
        check("t6_pre_valid", bus.out_valid, 1);
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_data", bus.out_data, 0);
        check("t6_rst_busy", bus.cfg_busy, 0);
        check("t6_rst_done", bus.cfg_done, 0);
        m_valid = 1'b0;
        m_data  = '0;
        m_tbl   = 4'b0101;
        m_en    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        check("t6_post_busy", bus.cfg_busy, 0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("t6_post_done", bus.cfg_done, 0);
        run_phase(2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
